// File: rtl/cmp_pkg.sv
// Shared types for the compare/condition datapath: condition codes, compare
// opcodes and the bit positions of the architectural {N,Z,C,V} flags.
package cmp_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_HS = 4'd2,
        COND_LO = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

    typedef enum logic [1:0] {
        OP_CMP = 2'd0,
        OP_CMN = 2'd1,
        OP_TST = 2'd2,
        OP_TEQ = 2'd3
    } cmp_op_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

endpackage

// File: rtl/cmp_flags_unit_cond_eval.sv
// Combinational condition-code evaluator: (condition, {N,Z,C,V}) -> taken.
// Kept standalone so a predication unit can reuse it against the same flags.
module cond_eval
    import cmp_pkg::*;
(
    input  logic [3:0] i_q_cond,
    input  logic [3:0] i_flags,
    output logic       o_take_next
);

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;

    // When the overflow feature is compiled out the caller ties V low, so the
    // V-dependent conditions collapse to VS=0, VC=1, GE=~N, LT=N.
    assign w_n = i_flags[N_IDX];
    assign w_z = i_flags[Z_IDX];
    assign w_c = i_flags[C_IDX];
    assign w_v = i_flags[V_IDX];

    always_comb begin
        o_take_next = 1'b0;
        case (cond_e'(i_q_cond))
            COND_EQ: o_take_next = w_z;
            COND_NE: o_take_next = ~w_z;
            COND_HS: o_take_next = w_c;
            COND_LO: o_take_next = ~w_c;
            COND_MI: o_take_next = w_n;
            COND_PL: o_take_next = ~w_n;
            COND_VS: o_take_next = w_v;
            COND_VC: o_take_next = ~w_v;
            COND_HI: o_take_next = w_c & ~w_z;
            COND_LS: o_take_next = ~w_c | w_z;
            COND_GE: o_take_next = (w_n == w_v);
            COND_LT: o_take_next = (w_n != w_v);
            COND_GT: o_take_next = ~w_z & (w_n == w_v);
            COND_LE: o_take_next = w_z | (w_n != w_v);
            COND_AL: o_take_next = 1'b1;
            COND_NV: o_take_next = 1'b0;
            default: o_take_next = 1'b0;
        endcase
    end

endmodule

// File: rtl/cmp_flags_unit.sv
// Two-stage compare pipeline producing {N,Z,C,V} plus a handshaked condition query.
// Define CMP_OVERFLOW_EN to build the V flag; otherwise V is tied to 0.
module cmp_flags_unit
    import cmp_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmp_valid,
    input  logic [1:0]       cmp_op,
    input  logic             imm_sel,
    input  logic [WIDTH-1:0] rn_data,
    input  logic [WIDTH-1:0] rm_data,
    input  logic [WIDTH-1:0] imm,
    input  logic             q_valid,
    input  logic [3:0]       q_cond,
    output logic             q_ready,
    output logic             take_valid,
    output logic             take,
    output logic [3:0]       flags
);

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    cmp_op_e          r_s1_op;

    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_c_next;
    logic             r_n;
    logic             r_z;
    logic             r_c;
    logic             w_v;

    logic             w_q_fire;
    logic             w_take_next;
    logic             r_take;
    logic             r_take_valid;

    assign w_b = imm_sel ? imm : rm_data;

    // Stage 1 captures every request; a newer compare simply overwrites the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_op    <= OP_CMP;
        end else begin
            r_s1_valid <= cmp_valid;
            if (cmp_valid) begin
                r_s1_a  <= rn_data;
                r_s1_b  <= w_b;
                r_s1_op <= cmp_op_e'(cmp_op);
            end
        end
    end

    always_comb begin
        w_sum    = '0;
        w_res    = '0;
        w_c_next = r_c;
        case (r_s1_op)
            OP_CMP: begin
                w_sum    = {1'b0, r_s1_a} - {1'b0, r_s1_b};
                w_res    = w_sum[WIDTH-1:0];
                w_c_next = ~w_sum[WIDTH];
            end
            OP_CMN: begin
                w_sum    = {1'b0, r_s1_a} + {1'b0, r_s1_b};
                w_res    = w_sum[WIDTH-1:0];
                w_c_next = w_sum[WIDTH];
            end
            OP_TST:  w_res = r_s1_a & r_s1_b;
            OP_TEQ:  w_res = r_s1_a ^ r_s1_b;
            default: w_res = '0;
        endcase
    end

    // Logical ops leave C (and V) untouched, which w_c_next already defaults to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n <= 1'b0;
            r_z <= 1'b0;
            r_c <= 1'b0;
        end else if (r_s1_valid) begin
            r_n <= w_res[WIDTH-1];
            r_z <= ~|w_res;
            r_c <= w_c_next;
        end
    end

`ifdef CMP_OVERFLOW_EN
    logic w_v_next;
    logic r_v;

    always_comb begin
        w_v_next = r_v;
        case (r_s1_op)
            OP_CMP:  w_v_next = (r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1]) &
                                (r_s1_a[WIDTH-1] ^ w_sum[WIDTH-1]);
            OP_CMN:  w_v_next = ~(r_s1_a[WIDTH-1] ^ r_s1_b[WIDTH-1]) &
                                 (r_s1_a[WIDTH-1] ^ w_sum[WIDTH-1]);
            default: w_v_next = r_v;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v <= 1'b0;
        end else if (r_s1_valid) begin
            r_v <= w_v_next;
        end
    end

    assign w_v = r_v;
`else
    assign w_v = 1'b0;
`endif

    assign flags = {r_n, r_z, r_c, w_v};

    // Queries wait behind any compare still in the pipe, so they never see stale flags.
    assign q_ready  = ~cmp_valid & ~r_s1_valid;
    assign w_q_fire = q_valid & q_ready;

    cond_eval u_cond_eval (
        .i_q_cond    (q_cond),
        .i_flags     (flags),
        .o_take_next (w_take_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_take       <= 1'b0;
            r_take_valid <= 1'b0;
        end else begin
            r_take_valid <= w_q_fire;
            if (w_q_fire) begin
                r_take <= w_take_next;
            end
        end
    end

    assign take       = r_take;
    assign take_valid = r_take_valid;

endmodule
